// File: rtl/patch_stream_scheduler_if.sv
// Beat stream from the patch scheduler to the patch-embedding engine.
// The scheduler carries no pixel data: the engine uses patch_idx/beat_idx
// to pick elements out of the patchifier's result array.
interface patch_stream_scheduler_if #(
  parameter int unsigned PIDX_W = 4,
  parameter int unsigned BIDX_W = 4
) ();

  logic              out_valid;
  logic              out_ready;
  logic [PIDX_W-1:0] patch_idx;
  logic [BIDX_W-1:0] beat_idx;
  logic              last_beat;
  logic              last_patch;

  // Scheduler side: drives the beat and its indices, receives backpressure.
  modport master (
    output out_valid,
    output patch_idx,
    output beat_idx,
    output last_beat,
    output last_patch,
    input  out_ready
  );

  // Embedding-engine side.
  modport slave (
    input  out_valid,
    input  patch_idx,
    input  beat_idx,
    input  last_beat,
    input  last_patch,
    output out_ready
  );

endinterface

// File: rtl/patch_stream_scheduler.sv
// patch_stream_scheduler: launches the patchifier, waits for its results,
// streams every patch out beat by beat as (patch_idx, beat_idx), then
// releases the patchifier and pulses done.
// Optional build macro PATCH_SCHED_STALL_CNT_EN adds a 32-bit saturating
// count of backpressured cycles (out_valid && !out_ready) on stall_cnt.
module patch_stream_scheduler #(
  parameter int unsigned TOTAL_NUM_PATCHES = 16,
  parameter int unsigned PATCH_VECTOR_SIZE = 256,
  parameter int unsigned BEAT_ELEMS        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ptf_en,
  input  logic [1:0]  ptf_state,
  output logic        ptf_output_taken,
`ifdef PATCH_SCHED_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  patch_stream_scheduler_if.master strm
);

  localparam int unsigned BEATS_PER_PATCH = PATCH_VECTOR_SIZE / BEAT_ELEMS;
  // Index widths are kept at least one bit so single-beat or single-patch
  // configurations still elaborate.
  localparam int unsigned PIDX_W = (TOTAL_NUM_PATCHES > 1) ? $clog2(TOTAL_NUM_PATCHES) : 1;
  localparam int unsigned BIDX_W = (BEATS_PER_PATCH > 1) ? $clog2(BEATS_PER_PATCH) : 1;

  localparam logic [1:0] PTF_IDLE = 2'b00;
  localparam logic [1:0] PTF_WORK = 2'b01;
  localparam logic [1:0] PTF_HOLD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STREAM,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t            state;
  logic              valid_q;
  logic [PIDX_W-1:0] patch_q;
  logic [BIDX_W-1:0] beat_q;

  logic start_accept;
  logic beat_at_end;
  logic patch_at_end;
  logic xfer;

  // A start coinciding with the done pulse is dropped so done always
  // separates two images by at least one idle cycle.
  assign start_accept = (state == S_IDLE) && start && !done;
  assign beat_at_end  = (beat_q == BIDX_W'(BEATS_PER_PATCH - 1));
  assign patch_at_end = (patch_q == PIDX_W'(TOTAL_NUM_PATCHES - 1));
  assign xfer         = valid_q && strm.out_ready;

  assign strm.out_valid  = valid_q;
  assign strm.patch_idx  = patch_q;
  assign strm.beat_idx   = beat_q;
  assign strm.last_beat  = valid_q && beat_at_end;
  assign strm.last_patch = valid_q && patch_at_end;

  // Sequencer: launch, wait, stream, release, drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      ptf_en           <= 1'b0;
      ptf_output_taken <= 1'b0;
      valid_q          <= 1'b0;
      patch_q          <= '0;
      beat_q           <= '0;
    end else begin
      done             <= 1'b0;
      ptf_output_taken <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_accept) begin
            state  <= S_LAUNCH;
            busy   <= 1'b1;
            ptf_en <= 1'b1;
          end
        end
        S_LAUNCH: begin
          // A patchifier already holding results skips straight to streaming.
          if (ptf_state == PTF_HOLD) begin
            state   <= S_STREAM;
            ptf_en  <= 1'b0;
            valid_q <= 1'b1;
            patch_q <= '0;
            beat_q  <= '0;
          end else if (ptf_state == PTF_WORK) begin
            state  <= S_WAIT;
            ptf_en <= 1'b0;
          end
        end
        S_WAIT: begin
          if (ptf_state == PTF_HOLD) begin
            state   <= S_STREAM;
            valid_q <= 1'b1;
            patch_q <= '0;
            beat_q  <= '0;
          end
        end
        S_STREAM: begin
          // Indices and valid only move on an accepted beat.
          if (xfer) begin
            if (beat_at_end) begin
              beat_q <= '0;
              if (patch_at_end) begin
                state            <= S_RELEASE;
                valid_q          <= 1'b0;
                patch_q          <= '0;
                ptf_output_taken <= 1'b1;
              end else begin
                patch_q <= patch_q + PIDX_W'(1);
              end
            end else begin
              beat_q <= beat_q + BIDX_W'(1);
            end
          end
        end
        S_RELEASE: begin
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (ptf_state == PTF_IDLE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          ptf_en  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PATCH_SCHED_STALL_CNT_EN
  // Backpressure counter: cleared per image, saturating, holds after done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (start_accept) begin
      stall_cnt <= '0;
    end else if (valid_q && !strm.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_patch_stream_scheduler.sv
// Bench for patch_stream_scheduler: a default-size instance driven through
// several image runs against a queue of expected (patch, beat) pairs, plus a
// 4-patch, single-beat-per-patch instance.
module tb_patch_stream_scheduler;

  localparam int NP    = 16;
  localparam int PVS   = 256;
  localparam int BE    = 16;
  localparam int BPP   = PVS / BE;
  localparam int NP_B  = 4;
  localparam int BE_B  = 256;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: default parameters
  logic        start_a = 1'b0;
  logic        busy_a, done_a, en_a, taken_a;
  logic [1:0]  pst_a;
  patch_stream_scheduler_if #(.PIDX_W(4), .BIDX_W(4)) sa ();

  // Instance B: 4 patches, one beat per patch
  logic        start_b = 1'b0;
  logic        busy_b, done_b, en_b, taken_b;
  logic [1:0]  pst_b;
  patch_stream_scheduler_if #(.PIDX_W(2), .BIDX_W(1)) sb ();

`ifdef PATCH_SCHED_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  patch_stream_scheduler #(
    .TOTAL_NUM_PATCHES(NP), .PATCH_VECTOR_SIZE(PVS), .BEAT_ELEMS(BE)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .ptf_en(en_a), .ptf_state(pst_a), .ptf_output_taken(taken_a),
`ifdef PATCH_SCHED_STALL_CNT_EN
    .stall_cnt(stall_a),
`endif
    .strm(sa)
  );

  patch_stream_scheduler #(
    .TOTAL_NUM_PATCHES(NP_B), .PATCH_VECTOR_SIZE(PVS), .BEAT_ELEMS(BE_B)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .ptf_en(en_b), .ptf_state(pst_b), .ptf_output_taken(taken_b),
`ifdef PATCH_SCHED_STALL_CNT_EN
    .stall_cnt(stall_b),
`endif
    .strm(sb)
  );

  // Patchifier model A: 00 -en-> 01 -(lat_a cycles)-> 10 -taken-> 00
  int unsigned lat_a = 0;
  int unsigned cnt_a;
  logic        load_a = 1'b0;
  logic [1:0]  load_val_a = 2'b00;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pst_a <= 2'b00;
      cnt_a <= 0;
    end else if (load_a) begin
      pst_a <= load_val_a;
    end else begin
      case (pst_a)
        2'b00: if (en_a) begin pst_a <= 2'b01; cnt_a <= lat_a; end
        2'b01: if (cnt_a == 0) pst_a <= 2'b10; else cnt_a <= cnt_a - 1;
        2'b10: if (taken_a) pst_a <= 2'b00;
        default: pst_a <= 2'b00;
      endcase
    end
  end

  // Patchifier model B, zero extra latency
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pst_b <= 2'b00;
    end else begin
      case (pst_b)
        2'b00: if (en_b) pst_b <= 2'b01;
        2'b01: pst_b <= 2'b10;
        2'b10: if (taken_b) pst_b <= 2'b00;
        default: pst_b <= 2'b00;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic check_a_outputs_zero(input string tag);
    check_val({tag, "_busy"}, busy_a, 0);
    check_val({tag, "_done"}, done_a, 0);
    check_val({tag, "_en"}, en_a, 0);
    check_val({tag, "_taken"}, taken_a, 0);
    check_val({tag, "_valid"}, sa.out_valid, 0);
    check_val({tag, "_patch"}, 32'(sa.patch_idx), 0);
    check_val({tag, "_beat"}, 32'(sa.beat_idx), 0);
    check_val({tag, "_lastb"}, sa.last_beat, 0);
    check_val({tag, "_lastp"}, sa.last_patch, 0);
`ifdef PATCH_SCHED_STALL_CNT_EN
    check_val({tag, "_stall"}, stall_a, 0);
`endif
  endtask

  // One image on instance A.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_a(input int ready_mode, input int lat, input bit stale,
                       input int dup_start_at, input int reset_at, input bit poke_on_done);
    int  q_p[$];
    int  q_b[$];
    int  xfers = 0;
    int  taken_cnt = 0;
    int  stall_exp = 0;
    int  cyc = 0;
    int  first_valid = -1;
    bit  seen_done = 1'b0;
    bit  dup_sent = 1'b0;
    bit  aborted = 1'b0;
    bit  rdy;
    logic [1:0] prev_pst = 2'b11;
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < BPP; b++) begin
        q_p.push_back(p);
        q_b.push_back(b);
      end
    lat_a = lat;
    @(negedge clk);
    if (stale) begin
      load_a = 1'b1;
      load_val_a = 2'b10;
      @(negedge clk);
      load_a = 1'b0;
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
`ifdef PATCH_SCHED_STALL_CNT_EN
    check_val("stall_clear", stall_a, 0);
`endif
    forever begin
      if (reset_at >= 0 && xfers == reset_at && sa.out_valid) begin
        #2 reset = 1'b0;
        #1 check_a_outputs_zero("async_rst");
        check_val("async_rst_pst", 32'(pst_a), 0);
        @(negedge clk);
        check_a_outputs_zero("rst_hold");
        reset = 1'b1;
        sa.out_ready = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done_a) begin
        check_val("done_busy", busy_a, 0);
        check_val("done_xfers", xfers, NP * BPP);
        check_val("done_taken_cnt", taken_cnt, 1);
        check_val("done_after_pst_idle", 32'(prev_pst), 0);
`ifdef PATCH_SCHED_STALL_CNT_EN
        check_val("stall_at_done", stall_a, stall_exp);
`endif
        seen_done = 1'b1;
        break;
      end
      check_val("busy", busy_a, 1);
      if (taken_a) begin
        taken_cnt++;
        check_val("taken_after_last", q_p.size(), 0);
      end
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      sa.out_ready = rdy;
      start_a = 1'b0;
      if (sa.out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          check_val("first_valid_latency", cyc, stale ? 2 : 4 + lat);
        end
        if (q_p.size() == 0) begin
          check_val("beat_overrun", q_p.size(), 1);
        end else begin
          check_val("patch_idx", 32'(sa.patch_idx), q_p[0]);
          check_val("beat_idx", 32'(sa.beat_idx), q_b[0]);
          check_val("last_beat", sa.last_beat, 32'(q_b[0] == BPP - 1));
          check_val("last_patch", sa.last_patch, 32'(q_p[0] == NP - 1));
          if (rdy) begin
            void'(q_p.pop_front());
            void'(q_b.pop_front());
            xfers++;
          end else begin
            stall_exp++;
          end
        end
        if (dup_start_at >= 0 && xfers >= dup_start_at && !dup_sent) begin
          start_a = 1'b1;
          dup_sent = 1'b1;
        end
      end else begin
        check_val("last_beat_no_valid", sa.last_beat, 0);
        check_val("last_patch_no_valid", sa.last_patch, 0);
      end
      prev_pst = pst_a;
      @(negedge clk);
      cyc++;
      if (cyc > BUDGET) break;
    end
    start_a = 1'b0;
    if (!aborted) begin
      check_val("done_seen", seen_done, 1);
      if (seen_done) begin
        start_a = poke_on_done;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          start_a = 1'b0;
          check_val("post_done_busy", busy_a, 0);
          check_val("post_done_done", done_a, 0);
          check_val("post_done_en", en_a, 0);
        end
`ifdef PATCH_SCHED_STALL_CNT_EN
        check_val("stall_hold", stall_a, stall_exp);
`endif
      end
    end
  endtask

  task automatic run_b();
    int  nb = 0;
    bit  got = 1'b0;
    sb.out_ready = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sb.out_valid) begin
        check_val("b_patch_idx", 32'(sb.patch_idx), nb);
        check_val("b_beat_idx", 32'(sb.beat_idx), 0);
        check_val("b_last_beat", sb.last_beat, 1);
        check_val("b_last_patch", sb.last_patch, 32'(nb == NP_B - 1));
        nb++;
      end
      if (done_b) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("b_done_seen", got, 1);
    check_val("b_xfers", nb, NP_B);
  endtask

  initial begin
    sa.out_ready = 1'b0;
    sb.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_a_outputs_zero("reset");
    check_val("reset_b_valid", sb.out_valid, 0);
    check_val("reset_b_busy", busy_b, 0);
    reset = 1'b1;
    @(negedge clk);
    check_a_outputs_zero("post_reset_idle");

    run_a(0, 0, 1'b0, -1, -1, 1'b0);   // basic
    run_a(1, 1, 1'b0, -1, -1, 1'b0);   // 1,0,0,1 backpressure
    run_a(0, 0, 1'b0, 100, -1, 1'b1);  // start while busy, start on done
    run_a(2, 2, 1'b1, -1, -1, 1'b0);   // stale patchifier, random ready
    run_a(0, 0, 1'b0, -1, 37, 1'b0);   // async reset mid-stream
    run_a(2, 0, 1'b0, -1, -1, 1'b0);   // restart from (0,0)
    run_b();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
